// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, fills a one-entry fetch register and
// shares the memory port with a program-load writer. Optional macro: IMEM_LOAD_EN.
module fetch_controller #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 16,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              load_valid,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              imem_we,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_instr,
  output logic              running
);

  localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              load_sel;

  assign running = (state == RUN);

`ifdef IMEM_LOAD_EN
  // Reset masks the write so an aborted load never reaches the memory.
  assign load_sel   = (state == IDLE) && load_valid && !rst;
  assign load_ready = (state == IDLE);
  assign imem_we    = load_sel;
  assign imem_wdata = load_sel ? load_data : '0;
  assign imem_addr  = load_sel ? load_addr : pc;
`else
  logic unused_load;
  assign unused_load = ^{load_valid, load_addr, load_data};
  assign load_sel    = 1'b0;
  assign load_ready  = 1'b0;
  assign imem_we     = load_sel;
  assign imem_wdata  = '0;
  assign imem_addr   = pc;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_ADDR;
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_instr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if_valid <= 1'b0;
          if (start) begin
            state <= RUN;
            pc    <= RESET_ADDR;
          end
        end
        RUN: begin
          // Priority: halt, redirect, stall, advance.
          if (halt) begin
            state    <= IDLE;
            if_valid <= 1'b0;
          end else if (redirect_valid) begin
            pc       <= redirect_pc;
            if_valid <= 1'b0;
          end else if (!stall) begin
            if_instr <= imem_rdata;
            if_pc    <= pc;
            if_valid <= 1'b1;
            pc       <= pc + ADDR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed self-checking bench for fetch_controller with a behavioural
// asynchronous-read instruction memory; load-port checks follow IMEM_LOAD_EN.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        halt;
  logic        stall;
  logic        redirect_valid;
  logic [9:0]  redirect_pc;
  logic        load_valid;
  logic [9:0]  load_addr;
  logic [15:0] load_data;
  logic        load_ready;
  logic [9:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_we;
  logic [15:0] imem_wdata;
  logic        if_valid;
  logic [9:0]  if_pc;
  logic [15:0] if_instr;
  logic        running;

  int checks = 0;
  int failures = 0;
  int weCount = 0;

`ifdef IMEM_LOAD_EN
  localparam bit LOAD_EN = 1'b1;
`else
  localparam bit LOAD_EN = 1'b0;
`endif

  logic [15:0] mem [0:1023];

  fetch_controller dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
    .load_ready(load_ready), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_we(imem_we), .imem_wdata(imem_wdata), .if_valid(if_valid),
    .if_pc(if_pc), .if_instr(if_instr), .running(running)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write committed at the clock edge.
  assign imem_rdata = mem[imem_addr];
  always @(posedge clk) begin
    if (imem_we) mem[imem_addr] <= imem_wdata;
    if (imem_we) weCount <= weCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_running"}, 32'(running), 32'd0);
    checkOutput({tag, "_if_valid"}, 32'(if_valid), 32'd0);
    checkOutput({tag, "_if_pc"}, 32'(if_pc), 32'd0);
    checkOutput({tag, "_if_instr"}, 32'(if_instr), 32'd0);
    checkOutput({tag, "_load_ready"}, 32'(load_ready), 32'(LOAD_EN));
    checkOutput({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
    checkOutput({tag, "_imem_wdata"}, 32'(imem_wdata), 32'd0);
  endtask

  task automatic checkFetch(input string tag, input logic [9:0] pc,
                            input logic [15:0] instr);
    checkOutput({tag, "_valid"}, 32'(if_valid), 32'd1);
    checkOutput({tag, "_pc"}, 32'(if_pc), 32'(pc));
    checkOutput({tag, "_instr"}, 32'(if_instr), 32'(instr));
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'h5A00 ^ 16'(i);
    mem[0] = 16'h2C03;
    mem[1] = 16'h8180;
    mem[2] = 16'h2204;

    rst = 1'b1; start = 1'b0; halt = 1'b0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    load_valid = 1'b0; load_addr = '0; load_data = '0;
    applyStimulus();
    applyStimulus();
    checkReset("reset");
    load_valid = 1'b1; load_addr = 10'd9; load_data = 16'hDEAD;
    #1;
    checkOutput("reset_masks_we", 32'(imem_we), 32'd0);
    load_valid = 1'b0;
    rst = 1'b0;

    // Basic fetch from RESET_PC.
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    checkOutput("start_running", 32'(running), 32'd1);
    checkOutput("start_no_valid", 32'(if_valid), 32'd0);
    applyStimulus(); checkFetch("fetch0", 10'd0, 16'h2C03);
    applyStimulus(); checkFetch("fetch1", 10'd1, 16'h8180);
    applyStimulus(); checkFetch("fetch2", 10'd2, 16'h2204);

    // Three-cycle stall holds the fetch register, then resumes at pc 3.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkFetch("stall_hold", 10'd2, 16'h2204);
    end
    stall = 1'b0;
    applyStimulus(); checkFetch("stall_resume", 10'd3, 16'h5A03);

    // Redirect beats stall and lands near the top of memory to exercise wrap.
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 10'd1022;
    applyStimulus();
    stall = 1'b0; redirect_valid = 1'b0;
    checkOutput("redir_bubble", 32'(if_valid), 32'd0);
    checkOutput("redir_pc_hold", 32'(if_pc), 32'd3);
    applyStimulus(); checkFetch("wrap1022", 10'd1022, 16'h59FE);
    applyStimulus(); checkFetch("wrap1023", 10'd1023, 16'h59FF);
    applyStimulus(); checkFetch("wrap0", 10'd0, 16'h2C03);
    applyStimulus(); checkFetch("wrap1", 10'd1, 16'h8180);

    // Halt while a load request is already pending.
    load_valid = 1'b1; load_addr = 10'd7; load_data = 16'hBEEF;
    halt = 1'b1;
    #1;
    checkOutput("run_no_we", 32'(imem_we), 32'd0);
    checkOutput("run_no_ready", 32'(load_ready), 32'd0);
    checkOutput("run_addr_pc", 32'(imem_addr), 32'd2);
    weCount = 0;
    applyStimulus();
    halt = 1'b0;
    checkOutput("halt_running", 32'(running), 32'd0);
    checkOutput("halt_valid", 32'(if_valid), 32'd0);
    checkOutput("halt_load_ready", 32'(load_ready), 32'(LOAD_EN));
    checkOutput("halt_we", 32'(imem_we), 32'(LOAD_EN));
    checkOutput("halt_addr", 32'(imem_addr), LOAD_EN ? 32'd7 : 32'd2);
    applyStimulus();
    load_valid = 1'b0;

    // Back-to-back loads to words 5 and 6.
    load_valid = 1'b1; load_addr = 10'd5; load_data = 16'h1234;
    applyStimulus();
    load_addr = 10'd6; load_data = 16'hABCD;
    applyStimulus();
    load_valid = 1'b0;
    applyStimulus();
    checkOutput("we_cycles", 32'(weCount), LOAD_EN ? 32'd3 : 32'd0);

    // Start then redirect immediately to 5; results depend on whether loads landed.
    start = 1'b1;
    applyStimulus();
    start = 1'b0; redirect_valid = 1'b1; redirect_pc = 10'd5;
    applyStimulus();
    redirect_valid = 1'b0;
    checkOutput("load_bubble", 32'(if_valid), 32'd0);
    applyStimulus(); checkFetch("load_word5", 10'd5, LOAD_EN ? 16'h1234 : 16'h5A05);
    applyStimulus(); checkFetch("load_word6", 10'd6, LOAD_EN ? 16'hABCD : 16'h5A06);
    redirect_valid = 1'b1; redirect_pc = 10'd7;
    applyStimulus();
    redirect_valid = 1'b0;
    applyStimulus(); checkFetch("load_word7", 10'd7, LOAD_EN ? 16'hBEEF : 16'h5A07);

    // Reset mid-run with a load request asserted.
    rst = 1'b1; load_valid = 1'b1; load_addr = 10'd9; load_data = 16'hDEAD;
    applyStimulus();
    load_valid = 1'b0;
    checkReset("midrun_reset");
    rst = 1'b0;

    // Halt in IDLE is ignored; the PC stays at its reset value.
    halt = 1'b1;
    applyStimulus();
    halt = 1'b0;
    checkOutput("idle_halt_running", 32'(running), 32'd0);
    checkOutput("idle_halt_addr", 32'(imem_addr), 32'd0);
    checkOutput("reset_no_write", 32'(mem[9]), 32'h5A09);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
